// File: rtl/bids22_round_seq.sv
//------------------------------------------------------------------------------
// Module   : bids22_round_seq
// Purpose  : Replays one latched round configuration as a command sequence to
//            the bids22 core, holds C_start for the round, then reports status.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bids22_round_seq #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_key,
    input  logic [31:0]      cfg_xval,
    input  logic [31:0]      cfg_yval,
    input  logic [31:0]      cfg_zval,
    input  logic [2:0]       cfg_mask,
    input  logic [31:0]      cfg_timer,
    input  logic [31:0]      cfg_cost,
    input  logic [CNT_W-1:0] round_len,
    input  logic             abort,
    input  logic             ready,
    input  logic [1:0]       err,
    input  logic             roundOver,
    output logic [3:0]       C_op,
    output logic [31:0]      C_data,
    output logic             C_start,
    output logic             done,
    output logic [1:0]       status,
    output logic [3:0]       fault_step
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, UNLOCK, LDX, LDY, LDZ, MASK, TIMER, COST, LOCK, RUN, WAIT, FIN
    } state_t;

    state_t             state, state_d, cmd_next;
    logic [31:0]        sh_key, sh_x, sh_y, sh_z, sh_timer, sh_cost;
    logic [2:0]         sh_mask;
    logic [CNT_W-1:0]   sh_len, cnt, cnt_d;
    logic [WAIT_W-1:0]  wcnt, wcnt_d;
    logic               pending, pend_d;
    logic [3:0]         last_op, last_d, cmd_op, op_d, fstep_d, fin_fs;
    logic [31:0]        cmd_data, data_d;
    logic [1:0]         status_d, fin_st;
    logic               start_d, done_d, fin;

    assign cfg_ready = (state == IDLE);

    // Command table: opcode, operand and successor for each command state
    always_comb begin
        cmd_op   = 4'd0;
        cmd_data = 32'd0;
        cmd_next = IDLE;
        case (state)
            UNLOCK:  begin cmd_op = 4'd1; cmd_data = sh_key;           cmd_next = LDX;   end
            LDX:     begin cmd_op = 4'd3; cmd_data = sh_x;             cmd_next = LDY;   end
            LDY:     begin cmd_op = 4'd4; cmd_data = sh_y;             cmd_next = LDZ;   end
            LDZ:     begin cmd_op = 4'd5; cmd_data = sh_z;             cmd_next = MASK;  end
            MASK:    begin cmd_op = 4'd6; cmd_data = {29'd0, sh_mask}; cmd_next = TIMER; end
            TIMER:   begin cmd_op = 4'd7; cmd_data = sh_timer;         cmd_next = COST;  end
            COST:    begin cmd_op = 4'd8; cmd_data = sh_cost;          cmd_next = LOCK;  end
            LOCK:    begin cmd_op = 4'd2; cmd_data = sh_key;           cmd_next = RUN;   end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state;
        op_d     = 4'd0;
        data_d   = 32'd0;
        start_d  = 1'b0;
        done_d   = 1'b0;
        status_d = status;
        fstep_d  = fault_step;
        pend_d   = 1'b0;
        last_d   = last_op;
        cnt_d    = cnt;
        wcnt_d   = wcnt;
        fin      = 1'b0;
        fin_st   = 2'b00;
        fin_fs   = 4'd0;
        case (state)
            IDLE: if (cfg_valid) state_d = UNLOCK;
            FIN:  state_d = IDLE;
            RUN: begin
                if (abort) begin
                    fin = 1'b1; fin_st = 2'b11;
                end else begin
                    start_d = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_d = WAIT;
                        wcnt_d  = '0;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    fin = 1'b1; fin_st = 2'b11;
                end else if (roundOver) begin
                    fin = 1'b1; fin_st = 2'b00;
                end else if (wcnt == WAIT_W'(TIMEOUT)) begin
                    fin = 1'b1; fin_st = 2'b10;
                end else begin
                    wcnt_d = wcnt + WAIT_W'(1);
                end
            end
            default: begin
                // err belongs to the command issued on the previous edge
                if (abort) begin
                    fin = 1'b1; fin_st = 2'b11;
                end else if (pending && err != 2'b00) begin
                    fin = 1'b1; fin_st = 2'b01; fin_fs = last_op;
                end else if (ready) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    pend_d  = 1'b1;
                    last_d  = cmd_op;
                    state_d = cmd_next;
                    cnt_d   = sh_len;
                end
            end
        endcase
        if (fin) begin
            state_d  = FIN;
            done_d   = 1'b1;
            status_d = fin_st;
            fstep_d  = fin_fs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            C_op       <= 4'd0;
            C_data     <= 32'd0;
            C_start    <= 1'b0;
            done       <= 1'b0;
            status     <= 2'b00;
            fault_step <= 4'd0;
            pending    <= 1'b0;
            last_op    <= 4'd0;
            cnt        <= '0;
            wcnt       <= '0;
            sh_key     <= 32'd0;
            sh_x       <= 32'd0;
            sh_y       <= 32'd0;
            sh_z       <= 32'd0;
            sh_mask    <= 3'd0;
            sh_timer   <= 32'd0;
            sh_cost    <= 32'd0;
            sh_len     <= '0;
        end else begin
            state      <= state_d;
            C_op       <= op_d;
            C_data     <= data_d;
            C_start    <= start_d;
            done       <= done_d;
            status     <= status_d;
            fault_step <= fstep_d;
            pending    <= pend_d;
            last_op    <= last_d;
            cnt        <= cnt_d;
            wcnt       <= wcnt_d;
            if (state == IDLE && cfg_valid) begin
                sh_key   <= cfg_key;
                sh_x     <= cfg_xval;
                sh_y     <= cfg_yval;
                sh_z     <= cfg_zval;
                sh_mask  <= cfg_mask;
                sh_timer <= cfg_timer;
                sh_cost  <= cfg_cost;
                sh_len   <= (round_len == '0) ? CNT_W'(1) : round_len;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bids22_round_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_bids22_round_seq
// Purpose  : Scoreboard bench for bids22_round_seq with a round-level model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bids22_round_seq;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 256;

    logic             clk, reset, cfg_valid, cfg_ready, abort, ready, roundOver;
    logic [31:0]      cfg_key, cfg_xval, cfg_yval, cfg_zval, cfg_timer, cfg_cost, C_data;
    logic [2:0]       cfg_mask;
    logic [CNT_W-1:0] round_len;
    logic [1:0]       err, status;
    logic [3:0]       C_op, fault_step;
    logic             C_start, done;

    bids22_round_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_key(cfg_key), .cfg_xval(cfg_xval), .cfg_yval(cfg_yval),
        .cfg_zval(cfg_zval), .cfg_mask(cfg_mask), .cfg_timer(cfg_timer),
        .cfg_cost(cfg_cost), .round_len(round_len), .abort(abort), .ready(ready),
        .err(err), .roundOver(roundOver), .C_op(C_op), .C_data(C_data),
        .C_start(C_start), .done(done), .status(status), .fault_step(fault_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [3:0] op; logic [31:0] data; } cmd_t;
    typedef struct { logic [1:0] st; logic [3:0] fs; int lat; } done_t;

    cmd_t  cmd_q[$];
    done_t done_q[$];
    int    len_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [31:0] k_key, k_x, k_y, k_z, k_timer, k_cost;
    logic [2:0]  k_mask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every issued command, C_start pulse and done is matched to the queues
    int  mon_hi = 0;
    int  mon_since = 0;
    logic mon_prev = 1'b0;
    initial begin : monitor
        cmd_t  c;
        done_t d;
        forever begin
            @(negedge clk);
            if (C_op != 4'd0) begin
                if (cmd_q.size() == 0) chk("unexpected_cmd", {60'd0, C_op}, 64'd0);
                else begin
                    c = cmd_q.pop_front();
                    chk("cmd_op", {60'd0, C_op}, {60'd0, c.op});
                    chk("cmd_data", {32'd0, C_data}, {32'd0, c.data});
                end
            end
            if (C_start) mon_hi++;
            else if (mon_prev) begin
                if (len_q.size() == 0) chk("unexpected_start", 64'(mon_hi), 64'd0);
                else chk("start_len", 64'(mon_hi), 64'(len_q.pop_front()));
                mon_hi = 0;
                mon_since = 0;
            end else mon_since++;
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", {63'd0, done}, 64'd0);
                else begin
                    d = done_q.pop_front();
                    chk("status", {62'd0, status}, {62'd0, d.st});
                    chk("fault_step", {60'd0, fault_step}, {60'd0, d.fs});
                    if (d.lat >= 0) chk("timeout_latency", 64'(mon_since), 64'(d.lat));
                end
            end
            mon_prev = C_start;
        end
    end

    task automatic rand_cfg();
        k_key = $urandom; k_x = $urandom; k_y = $urandom; k_z = $urandom;
        k_mask = 3'($urandom); k_timer = $urandom; k_cost = $urandom;
    endtask

    task automatic build_seq(output cmd_t seq[8]);
        seq[0] = '{4'd1, k_key};  seq[1] = '{4'd3, k_x};
        seq[2] = '{4'd4, k_y};    seq[3] = '{4'd5, k_z};
        seq[4] = '{4'd6, {29'd0, k_mask}};
        seq[5] = '{4'd7, k_timer}; seq[6] = '{4'd8, k_cost};
        seq[7] = '{4'd2, k_key};
    endtask

    task automatic handshake(input logic [CNT_W-1:0] len);
        for (int n = 0; n < 50 && !cfg_ready; n++) @(negedge clk);
        chk("cfg_ready_before_hs", {63'd0, cfg_ready}, 64'd1);
        cfg_valid = 1'b1; cfg_key = k_key; cfg_xval = k_x; cfg_yval = k_y;
        cfg_zval = k_z; cfg_mask = k_mask; cfg_timer = k_timer; cfg_cost = k_cost;
        round_len = len;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_key = $urandom; cfg_xval = $urandom; cfg_yval = $urandom;
        cfg_zval = $urandom; cfg_mask = 3'($urandom); cfg_timer = $urandom;
        cfg_cost = $urandom; round_len = CNT_W'($urandom);
    endtask

    task automatic run_round(input logic [CNT_W-1:0] len, input int fault_op,
                             input int abort_run, input int abort_wait, input int ro_delay,
                             input bit rnd_ready, input bit exact, input bit stall);
        cmd_t seq[8];
        int   tl[16];
        int   nops, eff_len, idx, lock_k, hi, wt, ab_k, done_k;
        bit   seen;
        build_seq(seq);
        eff_len = (len == 0) ? 1 : int'(len);
        nops = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back(seq[i]);
            nops++;
            if (int'(seq[i].op) == fault_op) break;
        end
        if (fault_op != 0)       done_q.push_back('{2'b01, 4'(fault_op), -1});
        else if (abort_run > 0) begin len_q.push_back(abort_run); done_q.push_back('{2'b11, 4'd0, -1}); end
        else if (abort_wait > 0) begin len_q.push_back(eff_len); done_q.push_back('{2'b11, 4'd0, -1}); end
        else if (ro_delay < 0) begin len_q.push_back(eff_len); done_q.push_back('{2'b10, 4'd0, TIMEOUT}); end
        else begin len_q.push_back(eff_len); done_q.push_back('{2'b00, 4'd0, -1}); end
        // Edge-by-edge issue timeline: one command per edge on which ready is high
        idx = 0; lock_k = -1;
        for (int j = 0; j < 16; j++) begin
            tl[j] = 0;
            if (j >= 1 && idx < nops && !(stall && j >= 3 && j <= 5)) begin
                tl[j] = int'(seq[idx].op);
                if (idx == 7) lock_k = j;
                idx++;
            end
        end
        handshake(len);
        hi = 0; wt = 0; seen = 1'b0; ab_k = -1; done_k = -1;
        for (int k = 0; k < 2000; k++) begin
            if (exact && k >= 1 && k <= 12 && done_k < 0)
                chk("op_timeline", {60'd0, C_op}, 64'(tl[k]));
            if (exact && lock_k > 0 && k == lock_k + 1)
                chk("start_latency", {63'd0, C_start}, 64'd1);
            if (ab_k >= 0 && k == ab_k + 1) begin
                chk("abort_start_low", {63'd0, C_start}, 64'd0);
                chk("abort_done", {63'd0, done}, 64'd1);
            end
            if (ab_k >= 0 && k == ab_k + 2) chk("abort_cfg_ready", {63'd0, cfg_ready}, 64'd1);
            if (done && done_k < 0) done_k = k;
            if (done_k >= 0 && k >= done_k + 1 && (ab_k < 0 || k >= ab_k + 2)) break;
            ready = rnd_ready ? ($urandom_range(0, 3) != 0) : !(stall && k >= 2 && k <= 4);
            err = (fault_op != 0 && int'(C_op) == fault_op) ? 2'b10 : 2'b00;
            if (C_start) begin hi++; seen = 1'b1; end
            else if (seen) wt++;
            abort = 1'b0;
            if (abort_run > 0 && C_start && hi == abort_run && ab_k < 0) begin abort = 1'b1; ab_k = k; end
            if (abort_wait > 0 && seen && !C_start && wt == abort_wait) abort = 1'b1;
            roundOver = (ro_delay > 0 && seen && !C_start && wt == ro_delay);
            @(negedge clk);
        end
        chk("round_completed", {63'd0, (done_k >= 0)}, 64'd1);
        ready = 1'b1; err = 2'b00; abort = 1'b0; roundOver = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_mid_run();
        cmd_t seq[8];
        int   hi;
        rand_cfg();
        build_seq(seq);
        foreach (seq[i]) cmd_q.push_back(seq[i]);
        len_q.push_back(3);
        handshake(CNT_W'(8));
        hi = 0;
        for (int k = 0; k < 100 && hi < 3; k++) begin
            if (C_start) hi++;
            if (hi < 3) @(negedge clk);
        end
        chk("run_reached", 64'(hi), 64'd3);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_start", {63'd0, C_start}, 64'd0);
        chk("async_reset_ready", {63'd0, cfg_ready}, 64'd1);
        repeat (2) @(negedge clk);
        chk("reset_status", {62'd0, status}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; abort = 1'b0; ready = 1'b1; err = 2'b00;
        roundOver = 1'b0; round_len = '0; cfg_key = '0; cfg_xval = '0; cfg_yval = '0;
        cfg_zval = '0; cfg_mask = '0; cfg_timer = '0; cfg_cost = '0;
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("rst_C_op", {60'd0, C_op}, 64'd0);
        chk("rst_C_data", {32'd0, C_data}, 64'd0);
        chk("rst_C_start", {63'd0, C_start}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_status_fs", {58'd0, status, fault_step}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        rand_cfg(); k_key = 32'h0F0F0F0F; k_x = 32'd100; k_y = 32'd200; k_z = 32'd300; k_mask = 3'b111;
        run_round(CNT_W'(4), 0, 0, 0, 2, 1'b0, 1'b1, 1'b0);
        rand_cfg();
        run_round(CNT_W'(3), 0, 0, 0, 1, 1'b0, 1'b1, 1'b1);
        rand_cfg();
        run_round(CNT_W'(4), 5, 0, 0, 2, 1'b0, 1'b1, 1'b0);
        rand_cfg();
        run_round(CNT_W'(2), 0, 0, 0, -1, 1'b0, 1'b1, 1'b0);
        rand_cfg();
        run_round(CNT_W'(10), 0, 2, 0, 2, 1'b0, 1'b1, 1'b0);
        rand_cfg();
        run_round(CNT_W'(3), 0, 0, 3, -1, 1'b0, 1'b0, 1'b0);
        reset_mid_run();
        rand_cfg();
        run_round(CNT_W'(0), 0, 0, 0, 3, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 24; r++) begin
            int sel, fop, len;
            int fops[7] = '{1, 3, 4, 5, 6, 7, 8};
            rand_cfg();
            sel = $urandom_range(0, 3);
            len = $urandom_range(2, 6);
            fop = fops[$urandom_range(0, 6)];
            case (sel)
                0: run_round(CNT_W'(len), fop, 0, 0, 2, 1'b1, 1'b0, 1'b0);
                1: run_round(CNT_W'(len), 0, $urandom_range(1, len - 1), 0, 2, 1'b1, 1'b0, 1'b0);
                default: run_round(CNT_W'(len), 0, 0, 0, $urandom_range(1, 5), 1'b1, 1'b0, 1'b0);
            endcase
        end

        repeat (4) @(negedge clk);
        chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        chk("len_q_empty", 64'(len_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
